// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max-pool over a raster pixel stream with optional ReLU; result registered 1 cycle
// after the odd-row/odd-col beat. No backpressure: upstream paces the stream with in_valid gaps.
module maxpool2x2_stream #(
   parameter int N    = 16,
   parameter int Q    = 12,
   parameter int W    = 8,
   parameter int H    = 8,
   parameter int RELU = 0
) (
   input  logic         clk,
   input  logic         sclr,
   input  logic         in_valid,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   output logic         frame_done
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int RW = (H > 1) ? $clog2(H) : 1;
   localparam int HW = W / 2;
   localparam int BW = (HW > 1) ? $clog2(HW) : 1;

   generate
      if ((W % 2) != 0 || W < 2 || (H % 2) != 0 || H < 2) begin : g_bad_dims
         $error("maxpool2x2_stream: W and H must be even and >= 2");
      end
      if (Q < 0 || Q >= N) begin : g_bad_q
         $error("maxpool2x2_stream: Q must lie in 0..N-1");
      end
   endgenerate

   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic signed [N-1:0] hold_q, hold_d;
   logic                out_valid_q, out_valid_d;
   logic signed [N-1:0] out_data_q, out_data_d;
   logic                frame_done_q, frame_done_d;

   // Horizontal pair maxima of the most recent even row, one entry per column pair.
   logic signed [N-1:0] lbuf_q [HW];

   logic signed [N-1:0] pix, hmax, above, pool_max, pool_res;
   logic                col_odd, row_odd, col_last, row_last, buf_wr;
   logic [BW-1:0]       bidx;

   assign pix      = $signed(in_data);
   assign col_odd  = col_q[0];
   assign row_odd  = row_q[0];
   assign col_last = (col_q == CW'(W - 1));
   assign row_last = (row_q == RW'(H - 1));
   assign bidx     = BW'(col_q >> 1);

   assign hmax     = (pix > hold_q) ? pix : hold_q;
   assign above    = lbuf_q[bidx];
   assign pool_max = (hmax > above) ? hmax : above;
   assign pool_res = (RELU != 0 && pool_max[N-1]) ? '0 : pool_max;

   assign buf_wr   = in_valid && col_odd && !row_odd && !sclr;

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hold_d       = hold_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      out_data_d   = out_data_q;
      if (in_valid) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (!col_odd) begin
            hold_d = pix;
         end else if (row_odd) begin
            out_valid_d  = 1'b1;
            out_data_d   = pool_res;
            // W is even, so col_last only ever occurs on an odd column.
            frame_done_d = row_last && col_last;
         end
      end
   end

   always_ff @(posedge clk or posedge sclr) begin
      if (sclr) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Not reset: each odd row only reads entries its preceding even row has just written.
   always_ff @(posedge clk) begin
      if (buf_wr) begin
         lbuf_q[bidx] <= hmax;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: directed and random frames against a whole-frame pooling model.
module tb_maxpool2x2_stream;

   logic        clk;
   logic        sclr;
   logic        vld [4];
   logic [15:0] dat [4];
   logic        ov  [4];
   logic [15:0] od  [4];
   logic        fd  [4];

   int ncmp;
   int nfail;

   logic signed [15:0] px [$];
   logic signed [15:0] exp_last [4];

   logic signed [15:0] d_relu0 [8];
   logic signed [15:0] d_relu1 [8];

   maxpool2x2_stream #(.N(16), .Q(12), .W(4), .H(2), .RELU(0)) u0 (
      .clk(clk), .sclr(sclr), .in_valid(vld[0]), .in_data(dat[0]),
      .out_valid(ov[0]), .out_data(od[0]), .frame_done(fd[0]));
   maxpool2x2_stream #(.N(16), .Q(12), .W(4), .H(2), .RELU(1)) u1 (
      .clk(clk), .sclr(sclr), .in_valid(vld[1]), .in_data(dat[1]),
      .out_valid(ov[1]), .out_data(od[1]), .frame_done(fd[1]));
   maxpool2x2_stream #(.N(16), .Q(12), .W(8), .H(8), .RELU(0)) u2 (
      .clk(clk), .sclr(sclr), .in_valid(vld[2]), .in_data(dat[2]),
      .out_valid(ov[2]), .out_data(od[2]), .frame_done(fd[2]));
   maxpool2x2_stream #(.N(16), .Q(12), .W(8), .H(4), .RELU(0)) u3 (
      .clk(clk), .sclr(sclr), .in_valid(vld[3]), .in_data(dat[3]),
      .out_valid(ov[3]), .out_data(od[3]), .frame_done(fd[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      ncmp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Streams px into instance k and checks every cycle against the pooled model of px.
   task automatic run(input int k, input int w, input int h, input int relu,
                      input int gap, input string tag);
      logic signed [15:0] exp_q [$];
      logic signed [15:0] m;
      logic signed [15:0] v;
      int fsz, nfr, idx, nobs, nexp, guard, p, r, c;
      bit pend, pend_last;
      fsz = w * h;
      nfr = px.size() / fsz;
      for (int f = 0; f < nfr; f++) begin
         for (int pr = 0; pr < h / 2; pr++) begin
            for (int pc = 0; pc < w / 2; pc++) begin
               m = px[f * fsz + 2 * pr * w + 2 * pc];
               for (int dr = 0; dr < 2; dr++) begin
                  for (int dc = 0; dc < 2; dc++) begin
                     v = px[f * fsz + (2 * pr + dr) * w + 2 * pc + dc];
                     if (v > m) m = v;
                  end
               end
               if (relu != 0 && m < 0) m = '0;
               exp_q.push_back(m);
            end
         end
      end
      nexp = exp_q.size();
      idx = 0; nobs = 0; guard = 0; pend = 1'b0; pend_last = 1'b0;
      while ((idx < px.size() || pend) && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (ov[k]) nobs++;
         check({tag, "_valid"}, 16'(ov[k]), 16'(pend));
         check({tag, "_fdone"}, 16'(fd[k]), 16'(pend && pend_last));
         if (pend) begin
            exp_last[k] = exp_q.pop_front();
         end
         check({tag, "_data"}, od[k], exp_last[k]);
         pend = 1'b0;
         pend_last = 1'b0;
         if (idx < px.size() && $urandom_range(99) >= gap) begin
            p = idx % fsz;
            r = p / w;
            c = p % w;
            vld[k] = 1'b1;
            dat[k] = px[idx];
            pend = (r % 2 == 1) && (c % 2 == 1);
            pend_last = (r == h - 1) && (c == w - 1);
            idx++;
         end else begin
            vld[k] = 1'b0;
            dat[k] = 16'($urandom);
         end
      end
      vld[k] = 1'b0;
      check({tag, "_beats"}, 16'(idx), 16'(px.size()));
      check({tag, "_count"}, 16'(nobs), 16'(nexp));
   endtask

   task automatic fill_random(input int n);
      px.delete();
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(7) == 0) px.push_back(16'sh8000);
         else                        px.push_back(16'($urandom));
      end
   endtask

   initial begin
      ncmp = 0;
      nfail = 0;
      d_relu0 = '{16'sd1, 16'sd5, -16'sd3, 16'sd2, 16'sd4, 16'sd0, -16'sd7, -16'sd1};
      d_relu1 = '{16'sd1, 16'sd5, -16'sd3, -16'sd2, 16'sd4, 16'sd0, -16'sd7, -16'sd1};
      for (int k = 0; k < 4; k++) begin
         vld[k] = 1'b0;
         dat[k] = '0;
         exp_last[k] = '0;
      end
      sclr = 1'b1;
      #3;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("reset_valid%0d", k), 16'(ov[k]), 16'h0000);
         check($sformatf("reset_data%0d", k), od[k], 16'h0000);
         check($sformatf("reset_fdone%0d", k), 16'(fd[k]), 16'h0000);
      end
      @(negedge clk);
      sclr = 1'b0;

      px.delete();
      foreach (d_relu0[i]) px.push_back(d_relu0[i]);
      run(0, 4, 2, 0, 0, "dir_relu0");

      px.delete();
      foreach (d_relu1[i]) px.push_back(d_relu1[i]);
      run(1, 4, 2, 1, 0, "dir_relu1");

      px.delete();
      for (int i = 0; i < 7; i++) px.push_back(16'sh8000);
      px.push_back(16'sh8001);
      run(0, 4, 2, 0, 0, "neg_extreme");

      fill_random(64);
      run(2, 8, 8, 0, 50, "rand_8x8");

      fill_random(96);
      run(3, 8, 4, 0, 0, "b2b_8x4");

      fill_random(32);
      run(1, 4, 2, 1, 30, "rand_relu");

      // Abort a frame partway through row 1, right after it has produced a pulse.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vld[0] = 1'b1;
         dat[0] = 16'(100 + i);
      end
      @(negedge clk);
      check("abort_pre_valid", 16'(ov[0]), 16'h0001);
      check("abort_pre_data", od[0], 16'd105);
      vld[0] = 1'b1;
      dat[0] = 16'd200;
      #2 sclr = 1'b1;
      #1;
      check("abort_rst_valid", 16'(ov[0]), 16'h0000);
      check("abort_rst_data", od[0], 16'h0000);
      check("abort_rst_fdone", 16'(fd[0]), 16'h0000);
      @(posedge clk);
      #2;
      check("abort_hold_valid", 16'(ov[0]), 16'h0000);
      vld[0] = 1'b0;
      @(negedge clk);
      sclr = 1'b0;
      for (int k = 0; k < 4; k++) exp_last[k] = '0;

      px.delete();
      for (int i = 0; i < 8; i++) px.push_back(16'($signed($urandom_range(100)) - 50));
      run(0, 4, 2, 0, 0, "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
